// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, 15-entry register file,
// source/destination selection and the valA/valB forwarding network.
module decode_stage #(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        D_stall_i,
  input  logic        D_bubble_i,
  input  logic [3:0]  f_icode_i,
  input  logic [3:0]  f_ifun_i,
  input  logic [3:0]  f_rA_i,
  input  logic [3:0]  f_rB_i,
  input  logic [63:0] f_valC_i,
  input  logic [63:0] f_valP_i,
  input  logic [3:0]  f_stat_i,
  input  logic [3:0]  e_dstE_i,
  input  logic [63:0] e_valE_i,
  input  logic [3:0]  M_dstE_i,
  input  logic [63:0] M_valE_i,
  input  logic [3:0]  M_dstM_i,
  input  logic [63:0] m_valM_i,
  input  logic [3:0]  W_dstE_i,
  input  logic [3:0]  W_dstM_i,
  input  logic [63:0] W_valE_i,
  input  logic [63:0] W_valM_i,
  output logic [3:0]  D_icode_o,
  output logic [3:0]  D_ifun_o,
  output logic [3:0]  D_rA_o,
  output logic [3:0]  D_rB_o,
  output logic [3:0]  D_stat_o,
  output logic [63:0] D_valC_o,
  output logic [63:0] D_valP_o,
  output logic [3:0]  d_srcA_o,
  output logic [3:0]  d_srcB_o,
  output logic [3:0]  d_dstE_o,
  output logic [3:0]  d_dstM_o,
  output logic [63:0] d_valA_o,
  output logic [63:0] d_valB_o
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RSP     = 4'h4;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;

  logic [63:0] rf [15];
  logic [63:0] rf_a, rf_b;

  // ---- D pipeline register (stall outranks bubble, reset outranks both) ----
  always_ff @(posedge clk_i) begin
    if (rst_i || (!D_stall_i && D_bubble_i)) begin
      D_icode_o <= INOP;
      D_ifun_o  <= 4'h0;
      D_rA_o    <= RNONE;
      D_rB_o    <= RNONE;
      D_valC_o  <= '0;
      D_valP_o  <= '0;
      D_stat_o  <= SAOK;
    end else if (!D_stall_i) begin
      D_icode_o <= f_icode_i;
      D_ifun_o  <= f_ifun_i;
      D_rA_o    <= f_rA_i;
      D_rB_o    <= f_rB_i;
      D_valC_o  <= f_valC_i;
      D_valP_o  <= f_valP_i;
      D_stat_o  <= f_stat_i;
    end
  end

  // ---- register file: M port is written second so it wins a same-register clash ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 15; i++)
        rf[i] <= (i == 4) ? RSP_INIT : 64'h0;
    end else begin
      if (W_dstE_i != RNONE) rf[W_dstE_i] <= W_valE_i;
      if (W_dstM_i != RNONE) rf[W_dstM_i] <= W_valM_i;
    end
  end

  // ---- decode: register selection ----
  always_comb begin
    d_srcA_o = RNONE;
    d_srcB_o = RNONE;
    d_dstE_o = RNONE;
    d_dstM_o = RNONE;
    case (D_icode_o)
      IRRMOVQ: begin d_srcA_o = D_rA_o; d_dstE_o = D_rB_o; end
      IIRMOVQ: d_dstE_o = D_rB_o;
      IRMMOVQ: begin d_srcA_o = D_rA_o; d_srcB_o = D_rB_o; end
      IMRMOVQ: begin d_srcB_o = D_rB_o; d_dstM_o = D_rA_o; end
      IOPQ:    begin d_srcA_o = D_rA_o; d_srcB_o = D_rB_o; d_dstE_o = D_rB_o; end
      ICALL:   begin d_srcB_o = RSP; d_dstE_o = RSP; end
      IRET:    begin d_srcA_o = RSP; d_srcB_o = RSP; d_dstE_o = RSP; end
      IPUSHQ:  begin d_srcA_o = D_rA_o; d_srcB_o = RSP; d_dstE_o = RSP; end
      IPOPQ:   begin d_srcA_o = RSP; d_srcB_o = RSP; d_dstE_o = RSP; d_dstM_o = D_rA_o; end
      default: ;
    endcase
  end

  // Nearest producer first: execute, memory read, memory E, writeback M, writeback E.
  function automatic logic [63:0] fwd_sel(input logic [3:0] src, input logic [63:0] rf_val);
    if (src == RNONE)          return 64'h0;
    else if (src == e_dstE_i)  return e_valE_i;
    else if (src == M_dstM_i)  return m_valM_i;
    else if (src == M_dstE_i)  return M_valE_i;
    else if (src == W_dstM_i)  return W_valM_i;
    else if (src == W_dstE_i)  return W_valE_i;
    else                       return rf_val;
  endfunction

  always_comb begin
    rf_a = 64'h0;
    rf_b = 64'h0;
    if (d_srcA_o != RNONE) rf_a = rf[d_srcA_o];
    if (d_srcB_o != RNONE) rf_b = rf[d_srcB_o];
  end

  always_comb begin
    if (D_icode_o == ICALL || D_icode_o == IJXX)
      d_valA_o = D_valP_o;
    else
      d_valA_o = fwd_sel(d_srcA_o, rf_a);
    d_valB_o = fwd_sel(d_srcB_o, rf_b);
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed sequences, an opcode table
// and randomized traffic compared against a behavioural pipeline model.
module tb_decode_stage;

  localparam logic [63:0] RSP_INIT = 64'h100;
  localparam logic [3:0]  F = 4'hF;

  logic        clk = 1'b0;
  logic        rst, stall, bubble;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_stat;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [3:0]  m_icode, m_ifun, m_rA, m_rB, m_stat;
  logic [63:0] m_valC, m_valP;
  logic [63:0] mrf [15];

  always #5 clk = ~clk;

  decode_stage #(.RSP_INIT(RSP_INIT)) dut (
    .clk_i(clk), .rst_i(rst), .D_stall_i(stall), .D_bubble_i(bubble),
    .f_icode_i(f_icode), .f_ifun_i(f_ifun), .f_rA_i(f_rA), .f_rB_i(f_rB),
    .f_valC_i(f_valC), .f_valP_i(f_valP), .f_stat_i(f_stat),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE), .M_dstE_i(M_dstE), .M_valE_i(M_valE),
    .M_dstM_i(M_dstM), .m_valM_i(m_valM), .W_dstE_i(W_dstE), .W_dstM_i(W_dstM),
    .W_valE_i(W_valE), .W_valM_i(W_valM),
    .D_icode_o(D_icode), .D_ifun_o(D_ifun), .D_rA_o(D_rA), .D_rB_o(D_rB),
    .D_stat_o(D_stat), .D_valC_o(D_valC), .D_valP_o(D_valP),
    .d_srcA_o(d_srcA), .d_srcB_o(d_srcB), .d_dstE_o(d_dstE), .d_dstM_o(d_dstM),
    .d_valA_o(d_valA), .d_valB_o(d_valB)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] x_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'hB, 4'h9}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] x_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h6, 4'h4, 4'h5}) return rb;
    if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] x_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
    return F;
  endfunction

  function automatic logic [3:0] x_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return F;
  endfunction

  function automatic logic [63:0] x_val(input logic [3:0] src);
    if (src == F) return 64'h0;
    if (src == e_dstE) return e_valE;
    if (src == M_dstM) return m_valM;
    if (src == M_dstE) return M_valE;
    if (src == W_dstM) return W_valM;
    if (src == W_dstE) return W_valE;
    return mrf[src];
  endfunction

  task automatic check_all(input string tag);
    logic [63:0] ea;
    check({tag, ".D_icode"}, 64'(D_icode), 64'(m_icode));
    check({tag, ".D_ifun"},  64'(D_ifun),  64'(m_ifun));
    check({tag, ".D_rA"},    64'(D_rA),    64'(m_rA));
    check({tag, ".D_rB"},    64'(D_rB),    64'(m_rB));
    check({tag, ".D_stat"},  64'(D_stat),  64'(m_stat));
    check({tag, ".D_valC"},  D_valC, m_valC);
    check({tag, ".D_valP"},  D_valP, m_valP);
    check({tag, ".d_srcA"},  64'(d_srcA), 64'(x_srcA(m_icode, m_rA)));
    check({tag, ".d_srcB"},  64'(d_srcB), 64'(x_srcB(m_icode, m_rB)));
    check({tag, ".d_dstE"},  64'(d_dstE), 64'(x_dstE(m_icode, m_rB)));
    check({tag, ".d_dstM"},  64'(d_dstM), 64'(x_dstM(m_icode, m_rA)));
    ea = (m_icode inside {4'h7, 4'h8}) ? m_valP : x_val(x_srcA(m_icode, m_rA));
    check({tag, ".d_valA"},  d_valA, ea);
    check({tag, ".d_valB"},  d_valB, x_val(x_srcB(m_icode, m_rB)));
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    if (rst) begin
      m_icode = 4'h1; m_ifun = 0; m_rA = F; m_rB = F; m_valC = 0; m_valP = 0; m_stat = 4'h1;
      for (int i = 0; i < 15; i++) mrf[i] = (i == 4) ? RSP_INIT : 64'h0;
    end else begin
      if (!stall && bubble) begin
        m_icode = 4'h1; m_ifun = 0; m_rA = F; m_rB = F; m_valC = 0; m_valP = 0; m_stat = 4'h1;
      end else if (!stall) begin
        m_icode = f_icode; m_ifun = f_ifun; m_rA = f_rA; m_rB = f_rB;
        m_valC = f_valC; m_valP = f_valP; m_stat = f_stat;
      end
      if (W_dstE != F) mrf[W_dstE] = W_valE;
      if (W_dstM != F) mrf[W_dstM] = W_valM;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_ifun = 0; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp; f_stat = 4'h1;
  endtask

  task automatic quiet_fwd();
    e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
  endtask

  typedef struct {
    logic [3:0] icode;
    logic [3:0] srcA, srcB, dstE, dstM;
  } vec_t;

  initial begin
    vec_t tbl [13];
    rst = 1; stall = 0; bubble = 0;
    fetch(4'h1, F, F, 0, 0);
    quiet_fwd();
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;

    // 1. reset, then POPQ reads the reset %rsp
    step();
    rst = 0;
    check("rst_icode", 64'(D_icode), 64'h1);
    check("rst_rA", 64'(D_rA), 64'hF);
    check("rst_rB", 64'(D_rB), 64'hF);
    check("rst_stat", 64'(D_stat), 64'h1);
    check("rst_srcA", 64'(d_srcA), 64'hF);
    check("rst_srcB", 64'(d_srcB), 64'hF);
    check("rst_valA", d_valA, 64'h0);
    check("rst_valB", d_valB, 64'h0);
    fetch(4'hB, 4'h7, F, 0, 0);
    step();
    check("popq_valA", d_valA, 64'h100);
    check("popq_valB", d_valB, 64'h100);

    // 2. load, stall two cycles, bubble
    fetch(4'h3, F, 4'h2, 64'h5, 64'hA);
    step();
    check("load_icode", 64'(D_icode), 64'h3);
    check("load_rB", 64'(D_rB), 64'h2);
    check("load_valC", D_valC, 64'h5);
    stall = 1;
    fetch(4'h6, 4'h1, 4'h1, 64'h77, 64'h99);
    step();
    fetch(4'h2, 4'h3, 4'h4, 64'h88, 64'h11);
    bubble = 1;
    step();
    check("stall_icode", 64'(D_icode), 64'h3);
    check("stall_valC", D_valC, 64'h5);
    check_all("stall");
    stall = 0;
    step();
    bubble = 0;
    check("bubble_icode", 64'(D_icode), 64'h1);
    check("bubble_rB", 64'(D_rB), 64'hF);

    // 3. write then read: W forward before the edge, rf after
    fetch(4'h2, 4'h3, 4'h6, 0, 0);
    step();
    W_dstE = 4'h3; W_valE = 64'h1234;
    #1;
    check("wfwd_valA", d_valA, 64'h1234);
    step();
    W_dstE = F;
    #1;
    check("rf_valA", d_valA, 64'h1234);

    // 4. forward priority
    fetch(4'h6, 4'h2, 4'h2, 0, 0);
    step();
    e_dstE = 4'h2; e_valE = 64'hAAAA;
    M_dstM = 4'h2; m_valM = 64'hBBBB;
    W_dstE = 4'h2; W_valE = 64'hCCCC;
    #1;
    check("prio_e_valA", d_valA, 64'hAAAA);
    check("prio_e_valB", d_valB, 64'hAAAA);
    e_dstE = F; #1;
    check("prio_m_valA", d_valA, 64'hBBBB);
    check("prio_m_valB", d_valB, 64'hBBBB);
    M_dstM = F; #1;
    check("prio_w_valA", d_valA, 64'hCCCC);
    check("prio_w_valB", d_valB, 64'hCCCC);
    M_dstE = 4'h2; M_valE = 64'hDDDD; #1;
    check("prio_ME_valA", d_valA, 64'hDDDD);
    quiet_fwd();

    // 5. dual write to the same register: M port wins
    W_dstE = 4'h5; W_valE = 64'h1; W_dstM = 4'h5; W_valM = 64'h2;
    fetch(4'h2, 4'h5, F, 0, 0);
    step();
    quiet_fwd();
    #1;
    check("dual_valA", d_valA, 64'h2);

    // 6. CALL and POPQ selection
    fetch(4'h8, F, F, 64'h0, 64'h40);
    step();
    check("call_valA", d_valA, 64'h40);
    check("call_srcB", 64'(d_srcB), 64'h4);
    check("call_dstE", 64'(d_dstE), 64'h4);
    check("call_dstM", 64'(d_dstM), 64'hF);
    fetch(4'hB, 4'h7, F, 0, 0);
    step();
    check("pop_srcA", 64'(d_srcA), 64'h4);
    check("pop_srcB", 64'(d_srcB), 64'h4);
    check("pop_dstE", 64'(d_dstE), 64'h4);
    check("pop_dstM", 64'(d_dstM), 64'h7);

    // mid-stream reset under stall discards D and overrides a write
    stall = 1; rst = 1; W_dstE = 4'h4; W_valE = 64'hDEAD;
    step();
    rst = 0; stall = 0; W_dstE = F;
    fetch(4'h9, F, F, 0, 0);
    check("rst_stall_icode", 64'(D_icode), 64'h1);
    step();
    check("rst_over_write", d_valA, 64'h100);

    // opcode table with rA=1, rB=2
    tbl = '{
      '{4'h0, F, F, F, F},          '{4'h1, F, F, F, F},
      '{4'h2, 4'h1, F, 4'h2, F},    '{4'h3, F, F, 4'h2, F},
      '{4'h4, 4'h1, 4'h2, F, F},    '{4'h5, F, 4'h2, F, 4'h1},
      '{4'h6, 4'h1, 4'h2, 4'h2, F}, '{4'h7, F, F, F, F},
      '{4'h8, F, 4'h4, 4'h4, F},    '{4'h9, 4'h4, 4'h4, 4'h4, F},
      '{4'hA, 4'h1, 4'h4, 4'h4, F}, '{4'hB, 4'h4, 4'h4, 4'h4, 4'h1},
      '{4'hC, F, F, F, F}
    };
    for (int i = 0; i < 13; i++) begin
      fetch(tbl[i].icode, 4'h1, 4'h2, 64'h0, 64'h0);
      step();
      check($sformatf("tbl%0d_srcA", i), 64'(d_srcA), 64'(tbl[i].srcA));
      check($sformatf("tbl%0d_srcB", i), 64'(d_srcB), 64'(tbl[i].srcB));
      check($sformatf("tbl%0d_dstE", i), 64'(d_dstE), 64'(tbl[i].dstE));
      check($sformatf("tbl%0d_dstM", i), 64'(d_dstM), 64'(tbl[i].dstM));
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      bubble = ($urandom_range(0, 5) == 0);
      f_icode = 4'($urandom_range(0, 12)); f_ifun = 4'($urandom);
      f_rA = 4'($urandom); f_rB = 4'($urandom); f_stat = 4'($urandom);
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      e_dstE = ($urandom_range(0, 2) == 0) ? 4'($urandom) : F;
      M_dstE = ($urandom_range(0, 2) == 0) ? 4'($urandom) : F;
      M_dstM = ($urandom_range(0, 2) == 0) ? 4'($urandom) : F;
      W_dstE = ($urandom_range(0, 1) == 0) ? 4'($urandom) : F;
      W_dstM = ($urandom_range(0, 1) == 0) ? 4'($urandom) : F;
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      #1;
      check_all($sformatf("rnd%0d", n));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Y86-64 pipeline decode stage: the D pipeline register, the 15-entry architectural register file, source/destination register selection and the valA/valB forwarding network. It consumes the fetch stage's f_* outputs at each clock edge and presents decoded operands to the execute pipeline register. It accepts stall/bubble control from pipeline control, and register-file writes and forwarded values from execute, memory and writeback.

## Interface

Parameters:
- RSP_INIT, 64'h0, reset value of %rsp (register 4); all other registers reset to 0.

Ports (`D_WORD` = 64 bits, `NIBBLE` = 4 bits). Clock and reset:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.

Pipeline control:
- D_stall_i  in  1  hold the D register.
- D_bubble_i  in  1  load a bubble into the D register.

Fetch inputs:
- f_icode_i, f_ifun_i, f_rA_i, f_rB_i  in  `NIBBLE` each  fetch outputs.
- f_valC_i, f_valP_i  in  `D_WORD` each  fetch outputs.
- f_stat_i  in  `NIBBLE`  fetch outputs.

Forwarding and writeback inputs:
- e_dstE_i  in  `NIBBLE`; e_valE_i  in  `D_WORD`  execute-stage forward.
- M_dstE_i  in  `NIBBLE`; M_valE_i  in  `D_WORD`  memory-register E forward.
- M_dstM_i  in  `NIBBLE`; m_valM_i  in  `D_WORD`  memory-read forward.
- W_dstE_i, W_dstM_i  in  `NIBBLE`; W_valE_i, W_valM_i  in  `D_WORD`  writeback ports; these also forward.

Registered outputs:
- D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_stat_o  out  `NIBBLE`.
- D_valC_o, D_valP_o  out  `D_WORD`.

Combinational outputs:
- d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o  out  `NIBBLE`.
- d_valA_o, d_valB_o  out  `D_WORD`.

## Operation

D register, updated at each rising edge, evaluated in this priority order:
- rst_i: load the bubble value.
- D_stall_i: hold the current contents.
- D_bubble_i: load the bubble value.
- Otherwise: load f_*.
- Bubble value: icode=`INOP` (1), ifun=0, rA=rB=`RNONE` (F), valC=valP=0, stat=`SAOK`.
- Stall and bubble asserted together is a control error; stall wins.

Register selection from D_icode (`RSP`=4, `RNONE`=F):
- srcA: rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ. `RSP` for POPQ, RET. Else `RNONE`.
- srcB: rB for OPQ, RMMOVQ, MRMOVQ. `RSP` for PUSHQ, POPQ, CALL, RET. Else `RNONE`.
- dstE: rB for RRMOVQ (includes cmovXX), IRMOVQ, OPQ. `RSP` for PUSHQ, POPQ, CALL, RET. Else `RNONE`.
- dstM: rA for MRMOVQ, POPQ. Else `RNONE`.
- Cmov condition squashing belongs to execute, not this block.

Register file:
- 15 x 64 bits, indices 0–14; index F is never stored.
- Two write ports (W_dstE/W_valE and W_dstM/W_valM), both written at the rising edge when the destination is not `RNONE`.
- If both ports target the same register in one cycle, W_valM wins.
- Reads are combinational; reading `RNONE` returns 0.
- There is no internal write-through; same-cycle visibility comes from W forwarding.
- rst_i clears all registers and sets %rsp to RSP_INIT, overriding any write in the same cycle.

valA select, first match wins:
1. D_icode is CALL or JXX: D_valP.
2. srcA==e_dstE: e_valE.
3. srcA==M_dstM: m_valM.
4. srcA==M_dstE: M_valE.
5. srcA==W_dstM: W_valM.
6. srcA==W_dstE: W_valE.
7. Otherwise: rf[srcA].

valB select: same chain as valA without step 1, using srcB.

Forward-match rule: a match is valid only when the source is not `RNONE`; `RNONE` sources always yield 0.

Load/use hazard detection is not done here; pipeline control drives the stall and bubble inputs.

## Timing

- D_* outputs change only at rising clk_i; reset values are the bubble value.
- d_* outputs are combinational from D_* plus the forwarding inputs; zero-cycle latency.
- Fetch-to-D latency is 1 cycle. Stall holds D for as many cycles as it is asserted.
- A register written at edge N reads from rf after edge N. In the cycle before edge N, the same value appears on d_valA/d_valB via W forwarding.
- Reset asserted mid-stream discards the D contents at the next edge. Stall does not block reset.

## Test plan

1. **Reset.** Assert rst_i for 1 cycle, with RSP_INIT=64'h100 -> D_icode=1, D_rA=D_rB=F, D_stat=`SAOK`, d_srcA=d_srcB=F, d_valA=d_valB=0. Then decode POPQ -> d_valA=d_valB=64'h100.
2. **Load, stall, bubble.** Present f_icode=3, rB=2, valC=64'h5 -> D_* loaded next edge. Hold D_stall_i 2 cycles with new f_* -> D_* unchanged. Assert D_bubble_i -> D_icode=1.
3. **Write then read.** Set W_dstE=3, W_valE=64'h1234 for one edge; D holds RRMOVQ rA=3 -> d_valA=64'h1234 both before the edge (W forward) and after it (rf).
4. **Forward priority.** Use OPQ with rA=2, rB=2. Set e_dstE=2/e_valE=A and M_dstM=2/m_valM=B, with W_dstE=2 -> d_valA=d_valB=A. Drop e -> B. Drop M -> W_valE.
5. **Dual-write conflict.** Set W_dstE=W_dstM=5, valE=1, valM=2 for one edge -> rf[5]=2, read via RRMOVQ rA=5 -> d_valA=2.
6. **CALL and POPQ.** CALL with valP=64'h40 -> d_valA=64'h40, d_srcB=4, d_dstE=4, d_dstM=F. POPQ rA=7 -> srcA=srcB=4, dstE=4, dstM=7.
